// File: rtl/tc_dev_if.sv
// tc_dev_if: bridge-bus view of the tc_dev timer.
// The CPU bridge is the master; the timer answers as the slave.
interface tc_dev_if;
   logic        Sel;
   logic        WE;
   logic [31:0] Addr;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   modport master (
      output Sel, WE, Addr, Din,
      input  Dout, IRQ
   );

   modport slave (
      input  Sel, WE, Addr, Din,
      output Dout, IRQ
   );
endinterface

// File: rtl/tc_dev.sv
// tc_dev: countdown timer peripheral on the external bridge bus.
// Registers CTRL, PRESET, COUNT plus a maskable interrupt line.
module tc_dev #(
   parameter int CNT_W = 32
) (
   input  logic    Clk,
   input  logic    Reset,
   tc_dev_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CNT,
      INT
   } state_e;

   localparam logic [1:0] A_CTRL = 2'b00;
   localparam logic [1:0] A_PRE  = 2'b01;
   localparam logic [1:0] A_CNT  = 2'b10;

   state_e           state_q;
   logic [3:0]       ctrl_q;
   logic [CNT_W-1:0] preset_q;
   logic [CNT_W-1:0] count_q;
   logic             irq_q;

   logic       wr;
   logic       wr_ctrl;
   logic       wr_pre;
   logic [1:0] reg_sel;
   logic       en;
   logic       auto_rl;
   logic       unused_addr;

   assign reg_sel     = bus.Addr[3:2];
   assign unused_addr = ^{bus.Addr[31:4], bus.Addr[1:0]};
   assign wr          = bus.Sel & bus.WE;
   assign wr_ctrl     = wr & (reg_sel == A_CTRL);
   assign wr_pre      = wr & (reg_sel == A_PRE);
   assign en          = ctrl_q[0];
   assign auto_rl     = (ctrl_q[2:1] == 2'b01);

   // CPU writes are placed after the FSM so they win on CTRL,
   // while an FSM set of the flag is placed after the write clear.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         ctrl_q   <= '0;
         preset_q <= '0;
         count_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         if (wr_ctrl || wr_pre) begin
            irq_q <= 1'b0;
         end
         if (wr_pre) begin
            preset_q <= CNT_W'(bus.Din);
         end
         unique case (state_q)
            IDLE: begin
               if (en) begin
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               count_q <= preset_q;
               state_q <= CNT;
            end
            CNT: begin
               if (!en) begin
                  state_q <= IDLE;
               end else if (count_q > CNT_W'(1)) begin
                  count_q <= count_q - CNT_W'(1);
               end else begin
                  count_q <= '0;
                  irq_q   <= 1'b1;
                  state_q <= INT;
               end
            end
            INT: begin
               state_q <= IDLE;
               if (auto_rl) begin
                  irq_q <= 1'b0;
               end else begin
                  ctrl_q[0] <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
         if (wr_ctrl) begin
            ctrl_q <= bus.Din[3:0];
         end
      end
   end

   always_comb begin
      bus.Dout = '0;
      case (reg_sel)
         A_CTRL:  bus.Dout = {28'h0, ctrl_q};
         A_PRE:   bus.Dout = 32'(preset_q);
         A_CNT:   bus.Dout = 32'(count_q);
         default: bus.Dout = '0;
      endcase
   end

   assign bus.IRQ = irq_q & ctrl_q[3];

endmodule

// File: tb/tb_tc_dev.sv
// tb_tc_dev: randomized scoreboard bench for the tc_dev timer.
// An edge-indexed timeline model predicts each cycle's read and IRQ.
module tb_tc_dev;

   logic Clk;
   logic Reset;

   tc_dev_if bus ();

   tc_dev #(.CNT_W(32)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   typedef struct packed {
      logic [1:0]  a;
      logic [31:0] dout;
      logic        irq;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   // Reference: a run starts at arming edge m_arm, loads at m_arm+1,
   // then counts arithmetically down to a fire edge.
   logic [3:0]  m_ctrl;
   logic [31:0] m_pre;
   logic [31:0] m_cnt;
   bit          m_flag;
   bit          m_busy;
   longint      m_e;
   longint      m_arm;
   longint      m_n;

   function automatic void m_reset();
      m_ctrl = '0;
      m_pre  = '0;
      m_cnt  = '0;
      m_flag = 0;
      m_busy = 0;
      m_e    = 0;
      m_arm  = 0;
      m_n    = 0;
   endfunction

   function automatic void m_edge(bit w, logic [1:0] a, logic [31:0] d);
      bit     en;
      bit     auto_rl;
      bit     set;
      longint fire;
      longint k;
      en      = m_ctrl[0];
      auto_rl = (m_ctrl[2:1] == 2'b01);
      set     = 0;
      if (!m_busy) begin
         if (en) begin
            m_busy = 1;
            m_arm  = m_e;
         end
      end else if (m_e == m_arm + 1) begin
         m_n   = {32'h0, m_pre};
         m_cnt = m_pre;
      end else begin
         fire = m_arm + 1 + ((m_n == 0) ? 1 : m_n);
         if (m_e <= fire) begin
            if (!en) begin
               m_busy = 0;
            end else begin
               k     = m_e - m_arm - 1;
               m_cnt = (m_n > k) ? 32'(m_n - k) : 32'h0;
               if (m_e == fire) begin
                  m_flag = 1;
                  set    = 1;
               end
            end
         end else begin
            m_busy = 0;
            if (auto_rl) m_flag = 0;
            else m_ctrl[0] = 1'b0;
         end
      end
      if (w && a == 2'd0) begin
         m_ctrl = d[3:0];
         if (!set) m_flag = 0;
      end
      if (w && a == 2'd1) begin
         m_pre = d;
         if (!set) m_flag = 0;
      end
      m_e++;
   endfunction

   function automatic logic [31:0] m_read(logic [1:0] a);
      case (a)
         2'd0:    return {28'h0, m_ctrl};
         2'd1:    return m_pre;
         2'd2:    return m_cnt;
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One bus cycle; optionally pulse Reset between edges first.
   task automatic cyc(bit rst, bit sel, bit we, logic [1:0] a,
                      logic [31:0] d, bit rhi);
      logic [31:0] r;
      exp_t        x;
      @(negedge Clk);
      if (rst) begin
         #1;
         bus.Sel = 1'b0;
         bus.WE  = 1'b0;
         Reset   = 1'b1;
         m_reset();
         for (int i = 0; i < 4; i++) begin
            bus.Addr = 32'(i) << 2;
            #1;
            chk("rst_read", bus.Dout, 32'h0);
         end
         chk("rst_irq", {31'h0, bus.IRQ}, 32'h0);
         Reset = 1'b0;
      end
      r        = rhi ? $urandom : 32'h0;
      bus.Sel  = sel;
      bus.WE   = we;
      bus.Addr = {r[31:4], a, r[1:0]};
      bus.Din  = d;
      m_edge(sel && we, a, d);
      x.a    = a;
      x.dout = m_read(a);
      x.irq  = m_flag & m_ctrl[3];
      sbq.push_back(x);
   endtask

   task automatic wr(logic [1:0] a, logic [31:0] d);
      cyc(0, 1, 1, a, d, 0);
   endtask

   task automatic rd(logic [1:0] a, int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, a, 32'h0, 0);
   endtask

   task automatic rst_rd(logic [1:0] a);
      cyc(1, 0, 0, a, 32'h0, 0);
   endtask

   always @(posedge Clk) begin
      exp_t x;
      #1;
      if (sbq.size() > 0) begin
         x = sbq.pop_front();
         chk($sformatf("dout_a%0d", x.a), bus.Dout, x.dout);
         chk("irq", {31'h0, bus.IRQ}, {31'h0, x.irq});
      end
   end

   initial begin
      logic [31:0] d;
      int          p;
      Reset    = 1'b1;
      bus.Sel  = 1'b0;
      bus.WE   = 1'b0;
      bus.Addr = '0;
      bus.Din  = '0;
      m_reset();
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      rd(0, 1);
      rd(1, 1);
      rd(2, 1);

      wr(1, 5);
      wr(0, 9);
      rd(2, 4);
      rst_rd(2);

      wr(1, 3);
      wr(0, 9);
      rd(2, 6);
      rd(0, 2);
      wr(1, 3);
      rd(0, 2);

      rst_rd(0);
      wr(1, 2);
      wr(0, 32'hB);
      for (int i = 0; i < 20; i++) rd((i % 2 == 0) ? 2'd0 : 2'd2, 1);

      rst_rd(0);
      wr(1, 4);
      wr(0, 1);
      rd(2, 3);
      wr(0, 0);
      rd(2, 4);
      rd(0, 1);

      rst_rd(0);
      wr(1, 7);
      wr(2, 32'hFFFF);
      cyc(0, 0, 1, 2'd1, 32'd99, 0);
      rd(3, 1);
      rd(1, 1);
      rd(2, 1);
      wr(3, 32'h1234);
      rd(1, 1);
      wr(0, 32'hFFFF_FFFF);
      rd(0, 2);

      rst_rd(0);
      wr(1, 2);
      wr(0, 9);
      rd(2, 4);
      wr(0, 9);
      rd(2, 6);
      rd(0, 1);

      rst_rd(0);
      for (int i = 0; i < 1500; i++) begin
         p = $urandom_range(0, 199);
         d = $urandom;
         if (p < 12) begin
            d[0] = ($urandom_range(0, 3) != 0);
            cyc(0, 1, 1, 2'd0, d, 1);
         end else if (p < 22) begin
            cyc(0, 1, 1, 2'd1, 32'($urandom_range(0, 6)), 1);
         end else if (p < 28) begin
            cyc(0, $urandom_range(0, 1) == 1, 1,
                2'($urandom_range(0, 3)), d, 1);
         end else if (p == 199) begin
            rst_rd(2'($urandom_range(0, 3)));
         end else begin
            cyc(0, 0, 0, 2'($urandom_range(0, 3)), d, 1);
         end
      end

      @(negedge Clk);
      bus.Sel = 1'b0;
      bus.WE  = 1'b0;
      repeat (2) @(posedge Clk);
      #2;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tc_dev.md
Name: tc_dev

Overview:
- Countdown timer peripheral on the CPU's external bridge bus.
- It is the responder end of the bus that the CPU memory stage drives with WE, Addr and write data, and from which it reads data back.
- The bridge decodes the address window and asserts Sel. The block provides three word registers and an interrupt line.
- Typical window: 0x7F00–0x7F0B.

Parameters:
- CNT_W, 32, width of the PRESET and COUNT registers.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Sel  input  1  bridge select for this device's address window.
- WE  input  1  write enable from the bridge; effective only when Sel=1.
- Addr  input  32  byte address; only Addr[3:2] is decoded.
- Din  input  32  write data (full word; byte enables not supported).
- Dout  output  32  read data, combinational from Addr[3:2].
- IRQ  output  1  interrupt request to the CPU.

Behaviour:
- Register map by Addr[3:2]:
  - 00 CTRL: bit0 Enable, bits[2:1] Mode, bit3 IM; bits[31:4] read as 0.
  - 01 PRESET: read/write.
  - 10 COUNT: read-only; writes ignored.
  - 11: reads 0; writes ignored.
- Writes:
  - Take effect at the rising edge where Sel&WE=1.
  - A CTRL write stores only Din[3:0].
  - Mode 00 is one-shot. Mode 01 is auto-reload. Modes 1x behave as 00.
- Reset (async): CTRL=0, PRESET=0, COUNT=0, irq flag=0, state=IDLE. IRQ drops to 0 immediately, independent of Clk.
- IRQ = irq_flag & CTRL.IM (combinational).
- FSM states and transitions:
  - IDLE: if Enable, go to LOAD; else stay.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT:
    - if !Enable, go to IDLE; COUNT holds its value.
    - else if COUNT>1, COUNT<=COUNT-1.
    - else COUNT<=0, irq_flag<=1, go to INT.
  - INT: go to IDLE.
    - Mode 00: Enable<=0; irq_flag stays 1.
    - Mode 01: irq_flag<=0, giving exactly a one-cycle pulse; Enable stays 1.
- irq_flag in mode 00 is cleared by any CPU write to CTRL or PRESET.
- PRESET=0 and PRESET=1 behave identically: the interrupt fires on the first CNT cycle.
- Latency:
  - Enable is written at edge E0. IDLE->LOAD occurs at E1. COUNT=PRESET at E2.
  - COUNT then decrements by 1 per edge until it reaches 0, at which point irq_flag=1.
  - With PRESET=N (N>=1), irq_flag=1 after edge E(N+2).
  - Mode 01 period between irq pulses is N+3 cycles.
- Simultaneous events:
  - A CPU write to CTRL at the same edge the FSM is in INT: the CPU-written value wins for all CTRL bits.
  - A CPU write that clears irq_flag at the same edge the FSM sets it: the set wins.
- A PRESET write during CNT does not affect the current count; it is used at the next LOAD.
- A write with Sel=0 has no effect.
- Reads have no side effects.
- COUNT wraps nowhere: it never decrements below 0.

Test Plan:
- Reset mid-count:
  - Stimulus: PRESET=5, CTRL=0x9 (Enable, mode 00, IM); assert Reset between edges while COUNT=3.
  - Required: IRQ=0 and all reads return 0 before the next edge.
- One-shot:
  - Stimulus: PRESET=3, CTRL=0x9 at E0.
  - Required: COUNT reads 3,2,1,0 after E2..E5; IRQ=1 after E5; CTRL reads 0x8 after E6; IRQ stays 1.
  - Then write PRESET=3: IRQ=0 next cycle.
- Auto-reload:
  - Stimulus: PRESET=2, CTRL=0xB.
  - Required: IRQ is a 1-cycle pulse, repeating every 5 cycles; CTRL stays 0xB.
- Masking and disable:
  - Stimulus: PRESET=4, CTRL=0x1.
  - Required: IRQ never rises.
  - Then write CTRL=0x0 while COUNT=2: COUNT holds 2 and the state returns to IDLE.
- Decode:
  - Stimulus: write 0xFFFF to COUNT; write with Sel=0 to PRESET; read Addr[3:2]=11.
  - Required: COUNT and PRESET unchanged; the 11 read returns 0; a CTRL write of 0xFFFFFFFF reads back 0xF.
- Collision:
  - Stimulus: mode 00, write CTRL=0x9 at the edge the FSM is in INT.
  - Required: Enable remains 1 and a new LOAD follows.
